q_update_pipe: RTL and testbench

- Pipelined Bellman-update datapath directly downstream of the Q-table action RAM.
- Consumes the current Q value, the packed next-state Q vector, the reward and the (state, action) tag.
- Computes Q_new = Q + alpha*(R + gamma*max_a Q(s',a) - Q) in signed fixed point.
- Issues the write-back (we/state/action/data) to the action RAM.

---
 rtl/q_update_pipe_pkg.sv | 46 ++++
 rtl/q_update_pipe_if.sv | 39 +++
 rtl/q_update_pipe_max_tree.sv | 24 ++
 rtl/q_update_pipe.sv | 118 +++++++++++
 tb/tb_q_update_pipe.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/q_update_pipe_pkg.sv
// Shared parameters, types and saturation helper for the Q-table Bellman update pipeline.
package q_update_pipe_pkg;

   localparam int DATA_WIDTH    = 16;
   localparam int FRAC_BITS     = 8;
   localparam int ACTIONS       = 4;
   localparam int ACTIONS_WIDTH = 2;
   localparam int STATES_WIDTH  = 4;

   localparam int STAGES = 4;
   localparam int TD_W   = DATA_WIDTH + 2;
   localparam int DL_W   = DATA_WIDTH + 3;
   localparam int SUM_W  = DATA_WIDTH + 4;

   localparam logic [FRAC_BITS:0]          ONE_FX = {1'b1, {FRAC_BITS{1'b0}}};
   localparam logic signed [DATA_WIDTH-1:0] Q_MAX  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [DATA_WIDTH-1:0] Q_MIN  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   typedef logic signed [DATA_WIDTH-1:0] q_t;
   typedef logic [FRAC_BITS:0]           fx_t;

   typedef struct packed {
      logic [STATES_WIDTH-1:0]  st;
      logic [ACTIONS_WIDTH-1:0] at;
   } tag_t;

   typedef struct packed {
      logic sat;
      q_t   q;
   } sat_res_t;

   function automatic sat_res_t clamp_q(input logic signed [SUM_W-1:0] s);
      sat_res_t r;
      r.sat = 1'b0;
      r.q   = s[DATA_WIDTH-1:0];
      if (s > SUM_W'(Q_MAX)) begin
         r.sat = 1'b1;
         r.q   = Q_MAX;
      end else if (s < SUM_W'(Q_MIN)) begin
         r.sat = 1'b1;
         r.q   = Q_MIN;
      end
      return r;
   endfunction

endpackage

// File: rtl/q_update_pipe_if.sv
// Sample-in / write-back-out bundle of q_update_pipe; o_greedy_at exists only with QUPDATE_GREEDY_EN.
interface q_update_if;
   import q_update_pipe_pkg::*;

   logic                             i_valid;
   logic [DATA_WIDTH-1:0]            i_q;
   logic [DATA_WIDTH*ACTIONS-1:0]    i_next_q;
   logic [DATA_WIDTH-1:0]            i_reward;
   logic [STATES_WIDTH-1:0]          i_st;
   logic [ACTIONS_WIDTH-1:0]         i_at;
   logic [FRAC_BITS:0]               i_alpha;
   logic [FRAC_BITS:0]               i_gamma;
   logic                             o_we;
   logic [STATES_WIDTH-1:0]          o_st;
   logic [ACTIONS_WIDTH-1:0]         o_at;
   logic [DATA_WIDTH-1:0]            o_data;
   logic                             o_sat;
   logic                             o_busy;
`ifdef QUPDATE_GREEDY_EN
   logic [ACTIONS_WIDTH-1:0]         o_greedy_at;
`endif

   modport master (
      output i_valid, i_q, i_next_q, i_reward, i_st, i_at, i_alpha, i_gamma,
      input  o_we, o_st, o_at, o_data, o_sat, o_busy
`ifdef QUPDATE_GREEDY_EN
      , o_greedy_at
`endif
   );

   modport slave (
      input  i_valid, i_q, i_next_q, i_reward, i_st, i_at, i_alpha, i_gamma,
      output o_we, o_st, o_at, o_data, o_sat, o_busy
`ifdef QUPDATE_GREEDY_EN
      , o_greedy_at
`endif
   );

endinterface

// File: rtl/q_update_pipe_max_tree.sv
// Combinational signed max/argmax over a packed lane vector; lowest index wins ties.
module q_max_tree #(
   parameter int ACTIONS    = 4,
   parameter int DATA_WIDTH = 16,
   parameter int IDX_W      = (ACTIONS > 1) ? $clog2(ACTIONS) : 1
) (
   input  logic [DATA_WIDTH*ACTIONS-1:0] vec,
   output logic signed [DATA_WIDTH-1:0]  max_q,
   output logic [IDX_W-1:0]              max_idx
);

   // Strict greater-than keeps the earlier lane on equality.
   always_comb begin
      max_q   = $signed(vec[DATA_WIDTH-1:0]);
      max_idx = '0;
      for (int k = 1; k < ACTIONS; k++) begin
         if ($signed(vec[DATA_WIDTH*k +: DATA_WIDTH]) > max_q) begin
            max_q   = $signed(vec[DATA_WIDTH*k +: DATA_WIDTH]);
            max_idx = IDX_W'(k);
         end
      end
   end

endmodule

// File: rtl/q_update_pipe.sv
// 4-stage Bellman update: Q + alpha*(R + gamma*maxQ' - Q), saturated, written back to the action RAM.
// Define QUPDATE_GREEDY_EN to also emit the argmax action of the next-state vector.
module q_update_pipe
   import q_update_pipe_pkg::*;
(
   input logic       clk,
   input logic       rst,
   q_update_if.slave bus
);

   logic [STAGES:1]          vld_pipe;
   q_t                       max_c;
   logic [ACTIONS_WIDTH-1:0] greedy_c;

   q_t                       q1, r1, max1, q2, q3, data_q;
   fx_t                      alpha1, gamma1, alpha2;
   tag_t                     tag1, tag2, tag3, tag_q;
   logic signed [TD_W-1:0]   td2, td_c;
   logic signed [DL_W-1:0]   delta3, delta_c;
   logic signed [DATA_WIDTH:0]              g_c;
   logic signed [DATA_WIDTH+FRAC_BITS+1:0]  gprod_c;
   logic signed [TD_W+FRAC_BITS+1:0]        dprod_c;
   sat_res_t                 res_c;
   logic                     sat_q;

   q_max_tree #(.ACTIONS(ACTIONS), .DATA_WIDTH(DATA_WIDTH), .IDX_W(ACTIONS_WIDTH)) u_max (
      .vec     (bus.i_next_q),
      .max_q   (max_c),
      .max_idx (greedy_c)
   );

   always_ff @(posedge clk) begin
      if (rst) vld_pipe <= '0;
      else     vld_pipe <= {vld_pipe[STAGES-1:1], bus.i_valid};
   end

   // S1: register the reduction result with the operands it will meet downstream.
   always_ff @(posedge clk) begin
      if (rst) begin
         q1 <= '0; r1 <= '0; max1 <= '0; alpha1 <= '0; gamma1 <= '0; tag1 <= '0;
      end else if (bus.i_valid) begin
         q1     <= $signed(bus.i_q);
         r1     <= $signed(bus.i_reward);
         max1   <= max_c;
         alpha1 <= bus.i_alpha;
         gamma1 <= bus.i_gamma;
         tag1   <= '{st: bus.i_st, at: bus.i_at};
      end
   end

   // S2: TD error; 18 bits covers the worst case of gamma just under 2.0.
   always_comb begin
      gprod_c = $signed({1'b0, gamma1}) * max1;
      g_c     = (DATA_WIDTH+1)'(gprod_c >>> FRAC_BITS);
      td_c    = TD_W'(r1) + TD_W'(g_c) - TD_W'(q1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q2 <= '0; td2 <= '0; alpha2 <= '0; tag2 <= '0;
      end else if (vld_pipe[1]) begin
         q2 <= q1; td2 <= td_c; alpha2 <= alpha1; tag2 <= tag1;
      end
   end

   // S3: scale by learning rate.
   always_comb begin
      dprod_c = $signed({1'b0, alpha2}) * td2;
      delta_c = DL_W'(dprod_c >>> FRAC_BITS);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q3 <= '0; delta3 <= '0; tag3 <= '0;
      end else if (vld_pipe[2]) begin
         q3 <= q2; delta3 <= delta_c; tag3 <= tag2;
      end
   end

   // S4: accumulate and clamp into the Q format.
   always_comb res_c = clamp_q(SUM_W'(q3) + SUM_W'(delta3));

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0; sat_q <= 1'b0; tag_q <= '0;
      end else if (vld_pipe[3]) begin
         data_q <= res_c.q; sat_q <= res_c.sat; tag_q <= tag3;
      end
   end

`ifdef QUPDATE_GREEDY_EN
   logic [ACTIONS_WIDTH-1:0] gat1, gat2, gat3, gat_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         gat1 <= '0; gat2 <= '0; gat3 <= '0; gat_q <= '0;
      end else begin
         if (bus.i_valid) gat1  <= greedy_c;
         if (vld_pipe[1]) gat2  <= gat1;
         if (vld_pipe[2]) gat3  <= gat2;
         if (vld_pipe[3]) gat_q <= gat3;
      end
   end

   assign bus.o_greedy_at = gat_q;
`else
   logic unused_greedy;
   assign unused_greedy = ^greedy_c;
`endif

   assign bus.o_we   = vld_pipe[STAGES];
   assign bus.o_busy = |vld_pipe;
   assign bus.o_data = data_q;
   assign bus.o_sat  = sat_q;
   assign bus.o_st   = tag_q.st;
   assign bus.o_at   = tag_q.at;

endmodule

// File: tb/tb_q_update_pipe.sv
// Directed-vector bench for q_update_pipe with hand-computed Q updates.
module tb_q_update_pipe;
   import q_update_pipe_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   q_update_if bus ();

   q_update_pipe dut (.clk(clk), .rst(rst), .bus(bus));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [15:0] q, input logic [63:0] nq, input logic [15:0] r,
                        input logic [3:0] st, input logic [1:0] at,
                        input logic [8:0] al, input logic [8:0] ga);
      bus.i_valid  = 1'b1;
      bus.i_q      = q;
      bus.i_next_q = nq;
      bus.i_reward = r;
      bus.i_st     = st;
      bus.i_at     = at;
      bus.i_alpha  = al;
      bus.i_gamma  = ga;
   endtask

   task automatic run_one(input string nm, input logic [15:0] q, input logic [63:0] nq,
                          input logic [15:0] r, input logic [3:0] st, input logic [1:0] at,
                          input logic [8:0] al, input logic [8:0] ga,
                          input logic [15:0] exp_d, input logic exp_sat, input logic [1:0] exp_g);
      drive(q, nq, r, st, at, al, ga);
      tick();
      bus.i_valid = 1'b0;
      chk({nm, ":busy_first"}, 32'(bus.o_busy), 32'd1);
      for (int c = 1; c < 4; c++) begin
         chk({nm, ":we_early"}, 32'(bus.o_we), 32'd0);
         tick();
      end
      chk({nm, ":we"},   32'(bus.o_we),   32'd1);
      chk({nm, ":busy_last"}, 32'(bus.o_busy), 32'd1);
      chk({nm, ":data"}, 32'(bus.o_data), 32'(exp_d));
      chk({nm, ":sat"},  32'(bus.o_sat),  32'(exp_sat));
      chk({nm, ":st"},   32'(bus.o_st),   32'(st));
      chk({nm, ":at"},   32'(bus.o_at),   32'(at));
`ifdef QUPDATE_GREEDY_EN
      chk({nm, ":greedy"}, 32'(bus.o_greedy_at), 32'(exp_g));
`else
      if (exp_g > 2'd3) $display("unreachable");
`endif
      tick();
      chk({nm, ":we_after"},  32'(bus.o_we),   32'd0);
      chk({nm, ":data_hold"}, 32'(bus.o_data), 32'(exp_d));
   endtask

   initial begin
      bus.i_valid = 1'b0; bus.i_q = '0; bus.i_next_q = '0; bus.i_reward = '0;
      bus.i_st = '0; bus.i_at = '0; bus.i_alpha = '0; bus.i_gamma = '0;
      rst = 1'b1;
      repeat (3) tick();
      chk("rst:we",   32'(bus.o_we),   32'd0);
      chk("rst:busy", 32'(bus.o_busy), 32'd0);
      chk("rst:data", 32'(bus.o_data), 32'd0);
      chk("rst:st",   32'(bus.o_st),   32'd0);
      chk("rst:at",   32'(bus.o_at),   32'd0);
      chk("rst:sat",  32'(bus.o_sat),  32'd0);
      rst = 1'b0;
      tick();

      // max=2.0, g=1.0, td=2.0, delta=1.0
      run_one("basic", 16'h0000, {16'hFF00, 16'h0080, 16'h0200, 16'h0100}, 16'h0100,
              4'd3, 2'd1, ONE_FX >> 1, ONE_FX >> 1, 16'h0100, 1'b0, 2'd1);
      // g=-0.5, td=-2.5, delta=-1.25
      run_one("neg", 16'h0000, {4{16'hFF00}}, 16'hFE00,
              4'd5, 2'd2, 9'd128, 9'd128, 16'hFEC0, 1'b0, 2'd0);
      // td=36862, sum=65534 -> clamp high
      run_one("sat_hi", 16'h7000, {16'h7FFF, 16'h7FFF, 16'h1000, 16'h0000}, 16'h7FFF,
              4'd9, 2'd3, 9'd256, 9'd256, 16'h7FFF, 1'b1, 2'd2);
      // g=-32768, td=-33024, sum=-65536 -> clamp low
      run_one("sat_lo", 16'h8100, {4{16'h8000}}, 16'h8000,
              4'd12, 2'd0, 9'd256, 9'd256, 16'h8000, 1'b1, 2'd0);
      run_one("ident", 16'h1234, {16'h0010, 16'h0300, 16'h0300, 16'hFFFF}, 16'h5000,
              4'd7, 2'd2, 9'd0, 9'd200, 16'h1234, 1'b0, 2'd1);
      // alpha=0.25: g=0.375, td=0.25+0.375-1.0=-0.375, delta=-0.09375 -> floor to -24/256
      run_one("frac", 16'h0100, {16'h0000, 16'h0000, 16'h0000, 16'h0100}, 16'h0040,
              4'd1, 2'd3, 9'd64, 9'd96, 16'h00E8, 1'b0, 2'd0);

      // Back-to-back: alpha=0 so each o_data echoes its own q.
      for (int i = 0; i < 4; i++) begin
         drive(16'h1000 + 16'(i), {4{16'h0100}}, 16'h0000, 4'(i), 2'(3 - i), 9'd0, 9'd128);
         tick();
         chk("b2b:busy_fill", 32'(bus.o_busy), 32'd1);
         if (i < 3) chk("b2b:we_early", 32'(bus.o_we), 32'd0);
      end
      bus.i_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("b2b:we",   32'(bus.o_we),   32'd1);
         chk("b2b:busy", 32'(bus.o_busy), 32'd1);
         chk("b2b:st",   32'(bus.o_st),   32'(i));
         chk("b2b:at",   32'(bus.o_at),   32'(3 - i));
         chk("b2b:data", 32'(bus.o_data), 32'h1000 + 32'(i));
         tick();
      end
      chk("b2b:we_end",   32'(bus.o_we),   32'd0);
      chk("b2b:busy_end", 32'(bus.o_busy), 32'd0);

      // Reset mid-flight: sample at N, rst during N+2.
      drive(16'h0000, {4{16'h0100}}, 16'h0100, 4'd6, 2'd1, 9'd128, 9'd128);
      tick();
      bus.i_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst:busy", 32'(bus.o_busy), 32'd0);
      chk("mid_rst:we",   32'(bus.o_we),   32'd0);
      chk("mid_rst:data", 32'(bus.o_data), 32'd0);
      chk("mid_rst:st",   32'(bus.o_st),   32'd0);
      for (int c = 4; c <= 8; c++) begin
         tick();
         chk("mid_rst:no_we", 32'(bus.o_we), 32'd0);
      end
      chk("mid_rst:data_hold", 32'(bus.o_data), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
